ins_loader: RTL and testbench
=============================

INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 Parameter: ADDR_W, 10, width of the word count and the write address.
REQ-002 CLK  in  1  the only clock; all state changes on its rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  begin a load; sampled in IDLE, DONE and ERR only.
REQ-005 load_len  in  ADDR_W  number of 32-bit words to load; captured when start is accepted.
REQ-006 abort  in  1  cancel an active load.
REQ-007 byte_in  in  8  program byte stream.
REQ-008 byte_valid  in  1  byte_in holds a valid byte.
REQ-009 byte_ready  out  1  loader can accept a byte this cycle.
REQ-010 WE  out  1  instruction-memory write strobe, one cycle per word.
REQ-011 W_Ins  out  32  assembled instruction word; valid while WE=1.
REQ-012 W_Addr  out  ADDR_W  word address of the current write.
REQ-013 cpu_rst  out  1  holds the processor core in reset.
REQ-014 busy  out  1  load in progress.
REQ-015 done  out  1  one-cycle pulse on successful completion.
REQ-016 err  out  1  sticky error flag.
REQ-017 words_loaded  out  ADDR_W  count of words written in the current or last load.

Function
REQ-018 States SHALL be: IDLE, LOAD, WRITE, CKSUM, DONE, ERR.
REQ-019 A byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1.
REQ-020 byte_ready SHALL be 1 only in the LOAD and CKSUM states.
REQ-021 From IDLE, DONE or ERR, start with load_len!=0 SHALL do all of the following: capture load_len, clear words_loaded, the byte counter and the checksum, clear err, and enter LOAD.
REQ-022 start with load_len=0 SHALL enter ERR with err=1.
REQ-023 start SHALL be ignored in LOAD, WRITE and CKSUM.
REQ-024 In LOAD, bytes SHALL be assembled little-endian: the first byte goes to W_Ins[7:0] and the fourth to W_Ins[31:24].
REQ-025 Each accepted data byte SHALL be added to an 8-bit running checksum, modulo 256.
REQ-026 On acceptance of the 4th byte of a word, the next state SHALL be WRITE.
REQ-027 WRITE SHALL last exactly one cycle, with WE=1, W_Ins holding the assembled word, and W_Addr=words_loaded.
REQ-028 On leaving WRITE, words_loaded SHALL increment.
REQ-029 After WRITE, if the incremented words_loaded equals the captured length, the next state SHALL be CKSUM; otherwise LOAD.
REQ-030 Gaps in byte_valid SHALL stall assembly without loss or corruption.
REQ-031 In CKSUM, the single accepted byte SHALL be compared with the running checksum: match enters DONE, mismatch enters ERR. The checksum byte itself SHALL not be summed.
REQ-032 DONE SHALL last one cycle with done=1, then go to IDLE unless start restarts a load.
REQ-033 ERR SHALL hold err=1 until an accepted start or RST.
REQ-034 abort in LOAD, WRITE or CKSUM SHALL enter ERR on the next edge.
REQ-035 When abort and the 4th byte arrive together, abort SHALL win: no WE is issued for that word.
REQ-036 When abort is asserted in WRITE, that cycle's WE SHALL still occur.
REQ-037 busy SHALL equal 1 in LOAD, WRITE and CKSUM.
REQ-038 cpu_rst SHALL equal busy OR err.
REQ-039 W_Addr SHALL not wrap: load_len=2^ADDR_W-1 is the maximum length.
REQ-040 WE, done and byte_ready SHALL be registered or state-decoded only, with no combinational path from byte_valid.

Reset
REQ-041 On RST=1, immediately and regardless of CLK, the block SHALL enter IDLE and hold every output at 0, including W_Ins and all counters and the checksum.
REQ-042 RST asserted mid-load SHALL discard any partial word and issue no WE.

Verification
REQ-043 load_len=2 with bytes 78 56 34 12 EF BE AD DE, then checksum 4C -> WE with W_Ins=0x12345678 at W_Addr 0, then WE with W_Ins=0xDEADBEEF at W_Addr 1, done pulse, words_loaded=2, cpu_rst=0.
REQ-044 Same stream with checksum 4D -> two WE pulses, no done, err=1, cpu_rst=1 until the next start.
REQ-045 Same stream with byte_valid toggled randomly at 50% -> identical WE words and addresses, done=1.
REQ-046 load_len=1, abort after 2 bytes -> no WE, err=1. A following start clears err and reloads correctly.
REQ-047 RST pulsed after 6 bytes of a 2-word load -> all outputs 0 with no clock edge required. A fresh load after release succeeds.
REQ-048 start with load_len=0 -> err=1. start during LOAD -> ignored, and the ongoing load completes unaffected.

Source files
------------

// File: rtl/ins_loader_if.sv
// Loader bundle: host control, byte stream with valid/ready, instruction-memory write port and status.
// Latency: none, signal bundle only.
// Backpressure: byte_ready from the loader throttles byte_valid from the host.
interface ins_loader_if #(
    parameter int ADDR_W = 10
);
    // host control
    logic              start;
    logic [ADDR_W-1:0] load_len;
    logic              abort;

    // program byte stream
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;

    // instruction memory write port
    logic              WE;
    logic [31:0]       W_Ins;
    logic [ADDR_W-1:0] W_Addr;

    // status
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] words_loaded;

    // host / bench side
    modport master (
        output start, load_len, abort, byte_in, byte_valid,
        input  byte_ready, WE, W_Ins, W_Addr, cpu_rst, busy, done, err, words_loaded
    );

    // loader side
    modport slave (
        input  start, load_len, abort, byte_in, byte_valid,
        output byte_ready, WE, W_Ins, W_Addr, cpu_rst, busy, done, err, words_loaded
    );
endinterface

// File: rtl/ins_loader.sv
// Instruction loader: packs a little-endian byte stream into 32-bit words, writes them to imem, verifies an 8-bit sum.
// Latency: WE one cycle after the 4th byte of a word; done/err one cycle after the checksum byte.
// Backpressure: byte_ready is state-decoded (LOAD/CKSUM only); bytes move only when byte_valid && byte_ready.
module ins_loader #(
    parameter int ADDR_W = 10
) (
    input  logic         CLK,
    input  logic         RST,
    ins_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CKSUM = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] len_q;      // captured word count of the running load
    logic [ADDR_W-1:0] wl_q;       // words written so far; also the write address
    logic [1:0]        bcnt_q;     // byte position inside the word being assembled
    logic [31:0]       word_q;     // word under assembly, presented on W_Ins
    logic [7:0]        sum_q;      // running modulo-256 sum of data bytes

    logic              rdy;
    logic              xfer;
    logic              start_acc;
    logic              start_ok;
    logic              last_byte;
    logic [ADDR_W-1:0] wl_inc;
    state_t            start_tgt;

    logic              we_c;
    logic              busy_c;
    logic              done_c;
    logic              err_c;

    // A start is honoured only while no load is running; a zero length is an error.
    assign start_acc = bus.start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign start_ok  = start_acc && (bus.load_len != '0);
    assign start_tgt = (bus.load_len != '0) ? LOAD : ERR;

    // byte_ready depends on state only, so no path from byte_valid reaches it.
    assign rdy       = (state == LOAD) || (state == CKSUM);
    assign xfer      = bus.byte_valid && rdy;
    assign last_byte = (bcnt_q == 2'd3);
    assign wl_inc    = wl_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        we_c      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;

        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_nxt = start_tgt;
                end
            end

            LOAD: begin
                busy_c = 1'b1;
                // abort beats a simultaneous 4th byte, so that word is never written
                if (bus.abort) begin
                    state_nxt = ERR;
                end else if (xfer && last_byte) begin
                    state_nxt = WRITE;
                end
            end

            WRITE: begin
                busy_c = 1'b1;
                // the strobe is issued for this cycle even when abort arrives with it
                we_c   = 1'b1;
                if (bus.abort) begin
                    state_nxt = ERR;
                end else if (wl_inc == len_q) begin
                    state_nxt = CKSUM;
                end else begin
                    state_nxt = LOAD;
                end
            end

            CKSUM: begin
                busy_c = 1'b1;
                if (bus.abort) begin
                    state_nxt = ERR;
                end else if (xfer) begin
                    state_nxt = (bus.byte_in == sum_q) ? DONE : ERR;
                end
            end

            DONE: begin
                done_c = 1'b1;
                state_nxt = start_acc ? start_tgt : IDLE;
            end

            ERR: begin
                err_c = 1'b1;
                if (start_acc) begin
                    state_nxt = start_tgt;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: length capture, byte packing, checksum and word counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_q  <= '0;
            wl_q   <= '0;
            bcnt_q <= 2'd0;
            word_q <= 32'h0;
            sum_q  <= 8'h0;
        end else if (start_ok) begin
            len_q  <= bus.load_len;
            wl_q   <= '0;
            bcnt_q <= 2'd0;
            word_q <= 32'h0;
            sum_q  <= 8'h0;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer && !bus.abort) begin
                        word_q[{bcnt_q, 3'b000} +: 8] <= bus.byte_in;
                        bcnt_q <= bcnt_q + 2'd1;
                        sum_q  <= sum_q + bus.byte_in;
                    end
                end
                WRITE: begin
                    wl_q <= wl_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.byte_ready   = rdy;
    assign bus.WE           = we_c;
    assign bus.W_Ins        = word_q;
    assign bus.W_Addr       = wl_q;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
    assign bus.err          = err_c;
    assign bus.cpu_rst      = busy_c || err_c;
    assign bus.words_loaded = wl_q;

    // The write strobe is a single-cycle pulse and never coincides with byte acceptance.
    a_we_single: assert property (@(posedge CLK) disable iff (RST) bus.WE |=> !bus.WE);
    a_we_no_rdy: assert property (@(posedge CLK) disable iff (RST) !(bus.WE && bus.byte_ready));

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: directed vector table plus multi-cycle sequences (gaps, mismatch, reset mid-load, max length).
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: bytes advance only when the bench saw byte_ready with byte_valid.
module tb_ins_loader;

    localparam int AW = 10;

    logic clk;
    logic rst;

    ins_loader_if #(.ADDR_W(AW)) bus ();

    ins_loader #(.ADDR_W(AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          st;
        logic [AW-1:0] len;
        logic          ab;
        logic          bv;
        logic [7:0]    b;
        logic          we;
        logic [31:0]   ins;
        logic [AW-1:0] addr;
        logic          dn;
        logic          er;
        logic          bz;
        logic          rdy;
        logic [AW-1:0] wl;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [AW-1:0] len, input logic ab,
                                input logic bv, input logic [7:0] b,
                                input logic we, input logic [31:0] ins, input logic [AW-1:0] addr,
                                input logic dn, input logic er, input logic bz, input logic rdy,
                                input logic [AW-1:0] wl);
        vec_t v;
        v.st = st; v.len = len; v.ab = ab; v.bv = bv; v.b = b;
        v.we = we; v.ins = ins; v.addr = addr;
        v.dn = dn; v.er = er; v.bz = bz; v.rdy = rdy; v.wl = wl;
        return v;
    endfunction

    function automatic logic [31:0] wgen(input int i);
        logic [15:0] k;
        k = 16'(i);
        if (i == 0) return 32'h12345678;
        if (i == 1) return 32'hDEADBEEF;
        return {k[7:0] ^ 8'h3C, k[7:0] + 8'd7, k[15:8], k[7:0]};
    endfunction

    task automatic drive(input logic st, input logic [AW-1:0] len, input logic ab,
                         input logic bv, input logic [7:0] b);
        bus.start      = st;
        bus.load_len   = len;
        bus.abort      = ab;
        bus.byte_valid = bv;
        bus.byte_in    = b;
    endtask

    // Full load of len generated words; ck_adj corrupts the checksum byte when nonzero.
    task automatic do_load(input string nm, input logic [AW-1:0] len, input bit rnd,
                           input logic [7:0] ck_adj);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        logic [31:0] w;
        int idx, nwe, bad, cyc, budget;
        bit dn, er, acc, bv, exp_done;

        sum = 8'h0;
        for (int i = 0; i < int'(len); i++) begin
            w = wgen(i);
            for (int j = 0; j < 4; j++) begin
                bytes.push_back(w[j*8 +: 8]);
                sum = sum + w[j*8 +: 8];
            end
        end
        bytes.push_back(sum + ck_adj);
        exp_done = (ck_adj == 8'h0);

        drive(1'b1, len, 1'b0, 1'b0, 8'h0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, 1'b0, 8'h0);

        idx = 0; nwe = 0; bad = 0; cyc = 0; dn = 0; er = 0;
        budget = int'(len) * 12 + 50;
        while (!(dn || er) && cyc < budget) begin
            bv = (idx < bytes.size()) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.byte_valid = bv;
            bus.byte_in    = bv ? bytes[idx] : 8'h00;
            acc = bv && bus.byte_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (bus.WE) begin
                if (bus.W_Ins !== wgen(nwe) || bus.W_Addr !== AW'(nwe)) bad++;
                nwe++;
            end
            if (bus.done) dn = 1;
            if (bus.err)  er = 1;
        end
        drive(1'b0, '0, 1'b0, 1'b0, 8'h0);

        chk({nm, "_finished"}, 64'(dn || er), 64'd1);
        chk({nm, "_we_count"}, 64'(nwe), 64'(len));
        chk({nm, "_we_data"},  64'(bad), 64'd0);
        chk({nm, "_done"},     64'(dn), 64'(exp_done));
        chk({nm, "_err"},      64'(bus.err), 64'(!exp_done));
        chk({nm, "_wl"},       64'(bus.words_loaded), 64'(len));
        chk({nm, "_cpu_rst"},  64'(bus.cpu_rst), 64'(!exp_done));
    endtask

    function automatic logic [63:0] all_out();
        return 64'({bus.WE, bus.W_Ins, bus.W_Addr, bus.busy, bus.done, bus.err,
                    bus.cpu_rst, bus.byte_ready, bus.words_loaded});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, exp;
        vec_t v;

        drive(1'b0, '0, 1'b0, 1'b0, 8'h0);
        rst = 1'b1;
        #3;
        chk("reset_outputs", all_out(), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // basic two-word load, good checksum
        tbl.push_back(mk(1,2,0,0,8'h00, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h78, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h56, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h34, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h12, 1,32'h12345678,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,8'hEF, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hEF, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hBE, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hAD, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hDE, 1,32'hDEADBEEF,1, 0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0, 0,0,1,1,2));
        tbl.push_back(mk(0,0,0,1,8'h4C, 0,0,0, 1,0,0,0,2));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0, 0,0,0,0,2));
        // same stream, bad checksum
        tbl.push_back(mk(1,2,0,0,8'h00, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h78, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h56, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h34, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h12, 1,32'h12345678,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hEF, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hBE, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hAD, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'hDE, 1,32'hDEADBEEF,1, 0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0, 0,0,1,1,2));
        tbl.push_back(mk(0,0,0,1,8'h4D, 0,0,0, 0,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0, 0,1,0,0,2));
        // zero length start stays in error; a real start clears it
        tbl.push_back(mk(1,0,0,0,8'h00, 0,0,0, 0,1,0,0,2));
        tbl.push_back(mk(1,1,0,0,8'h00, 0,0,0, 0,0,1,1,0));
        // abort after two bytes
        tbl.push_back(mk(0,0,0,1,8'h11, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,1,1,8'h22, 0,0,0, 0,1,0,0,0));
        // reload after abort
        tbl.push_back(mk(1,1,0,0,8'h00, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h01, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h02, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h03, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h04, 1,32'h04030201,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(0,0,0,1,8'h0A, 0,0,0, 1,0,0,0,1));
        // restart straight out of DONE, then abort together with the 4th byte
        tbl.push_back(mk(1,1,0,0,8'h00, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'hA1, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'hA2, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'hA3, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,1,1,8'hA4, 0,0,0, 0,1,0,0,0));
        // abort during WRITE: strobe already issued, count still advances
        tbl.push_back(mk(1,2,0,0,8'h00, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h10, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h20, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h30, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h40, 1,32'h40302010,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00, 0,0,0, 0,1,0,0,1));
        // start ignored while LOAD/WRITE/CKSUM are active
        tbl.push_back(mk(1,1,0,0,8'h00, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(1,3,0,1,8'h05, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h06, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h07, 0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,8'h08, 1,32'h08070605,0, 0,0,1,0,0));
        tbl.push_back(mk(1,5,0,0,8'h00, 0,0,0, 0,0,1,1,1));
        tbl.push_back(mk(1,3,0,1,8'h1A, 0,0,0, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0, 0,0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.st, v.len, v.ab, v.bv, v.b);
            @(posedge clk); #1;
            got = 64'({bus.WE, bus.WE ? bus.W_Ins : 32'h0, bus.WE ? bus.W_Addr : AW'(0),
                       bus.done, bus.err, bus.busy, bus.byte_ready, bus.words_loaded, bus.cpu_rst});
            exp = 64'({v.we, v.we ? v.ins : 32'h0, v.we ? v.addr : AW'(0),
                       v.dn, v.er, v.bz, v.rdy, v.wl, v.bz | v.er});
            chk($sformatf("vec%0d", i), got, exp);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 8'h0);

        // gapped byte_valid, then checksum mismatch via the generic loader
        do_load("gaps", 10'd2, 1'b1, 8'h00);
        do_load("bad_ck", 10'd2, 1'b0, 8'h01);

        // asynchronous reset after six bytes of a two-word load
        drive(1'b1, 10'd2, 1'b0, 1'b0, 8'h0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, 1'b1, 8'h78); @(posedge clk); #1;
        bus.byte_in = 8'h56; @(posedge clk); #1;
        bus.byte_in = 8'h34; @(posedge clk); #1;
        bus.byte_in = 8'h12; @(posedge clk); #1;
        bus.byte_valid = 1'b0; @(posedge clk); #1;
        bus.byte_valid = 1'b1; bus.byte_in = 8'hEF; @(posedge clk); #1;
        bus.byte_in = 8'hBE; @(posedge clk); #1;
        chk("pre_reset_wl", 64'(bus.words_loaded), 64'd1);
        bus.byte_in = 8'hAD;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", all_out(), 64'd0);
        bus.byte_in = 8'hDE;
        @(posedge clk); #1;
        chk("reset_no_we", 64'(bus.WE), 64'd0);
        @(posedge clk); #1;
        chk("reset_held_outputs", all_out(), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 8'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", all_out(), 64'd0);
        do_load("after_reset", 10'd2, 1'b0, 8'h00);

        // longest legal load: addresses run up to 2^AW-2 without wrapping
        do_load("max_len", 10'd1023, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
